// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, exception codes and the
// EXE->MEM bus layout as a packed struct.
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD = 171;
   localparam int MS_TO_WS_BUS_WD = 160;
   localparam int MS_FWD_WD       = 60;

   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_PIL = 6'h01;
   localparam logic [5:0] ECODE_ADE = 6'h08;
   localparam logic [5:0] ECODE_ALE = 6'h09;
   localparam logic [5:0] ECODE_SYS = 6'h0b;
   localparam logic [5:0] ECODE_BRK = 6'h0c;
   localparam logic [5:0] ECODE_INE = 6'h0d;

   typedef struct packed {
      logic ld_w;
      logic ld_b;
      logic ld_bu;
      logic ld_h;
      logic ld_hu;
   } ld_type_t;

   typedef struct packed {
      logic        st_w;
      logic        rdcntid;
      logic        ertn;
      logic        esubcode;
      logic [5:0]  ecode;
      logic        ex;
      logic        csr_re;
      logic [13:0] csr_num;
      logic [31:0] wvalue;
      logic [31:0] wmask;
      logic        csr_we;
      logic [1:0]  addr_lo;
      ld_type_t    ld;
      logic        st_b;
      logic        st_h;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } es_bus_t;

   // Any load or store: such an op has a data-SRAM request in flight unless it carries ex.
   function automatic logic is_mem_op(input es_bus_t b);
      return b.res_from_mem | b.st_b | b.st_h | b.st_w;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align: selects the addressed byte/halfword of a load word and
// sign- or zero-extends it to 32 bits (purely combinational).
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  ld_type_t    ld,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [31:0] shifted;

   assign shifted = word >> {addr_lo, 3'b000};

   // Extension select; a plain word load takes the shifted word as-is.
   always_comb begin
      result = shifted;
      if (ld.ld_b) begin
         result = {{24{shifted[7]}}, shifted[7:0]};
      end else if (ld.ld_bu) begin
         result = {24'h000000, shifted[7:0]};
      end else if (ld.ld_h) begin
         result = {{16{shifted[15]}}, shifted[15:0]};
      end else if (ld.ld_hu) begin
         result = {16'h0000, shifted[15:0]};
      end else begin
         result = shifted;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one EXE op, waits for its data-SRAM response,
// aligns load data and discards responses orphaned by a flush.
// Optional macro MS_LOAD_FWD_EN: forward aligned load data to ID from MEM.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       final_ex,
   input  logic                       back_ertn_flush,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic [MS_FWD_WD-1:0]       ms_forward,
   output logic                       ms_ertn_flush,
   output logic                       ms_ex,
   output logic                       ms_to_es_valid
);

   es_bus_t     bus_in;
   es_bus_t     ms_bus;
   logic        ms_valid;
   logic        buf_vld;
   logic [31:0] rdata_buf;
   logic [1:0]  drop_cnt;
   logic [1:0]  drop_cnt_next;

   logic        flush;
   logic        mem_wait;
   logic        data_ok_use;
   logic        ms_ready_go;
   logic        inc_wait;
   logic        inc_hand;
   logic        dec_drop;
   logic [31:0] load_word;
   logic [31:0] load_data;
   logic [31:0] final_result;
   logic [31:0] fwd_result;
   logic        data_vld;

   assign bus_in      = es_to_ms_bus;
   assign flush       = final_ex | back_ertn_flush;
   assign mem_wait    = ms_valid & is_mem_op(ms_bus) & ~ms_bus.ex;
   assign data_ok_use = data_sram_data_ok & (drop_cnt == 2'd0);
   assign ms_ready_go = ~mem_wait | buf_vld | data_ok_use;
   assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
   assign ms_to_ws_valid = ms_valid & ms_ready_go;
   assign ms_to_es_valid = ms_valid;
   assign ms_ex          = ms_valid & ms_bus.ex;
   assign ms_ertn_flush  = ms_valid & ms_bus.ertn;

   // Stage valid bit; a flush wins over any handoff from EXE.
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid <= 1'b0;
      end else if (flush) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
      end else begin
         ms_valid <= ms_valid;
      end
   end

   // Latch the EXE bus on every accepted handoff.
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_bus <= '0;
      end else if (es_to_ms_valid & ms_allowin) begin
         ms_bus <= bus_in;
      end else begin
         ms_bus <= ms_bus;
      end
   end

   // Response buffer: data_ok cannot be stalled, so park it while WB is busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_vld   <= 1'b0;
         rdata_buf <= 32'h0000_0000;
      end else if (flush) begin
         buf_vld   <= 1'b0;
         rdata_buf <= rdata_buf;
      end else if (buf_vld & ms_to_ws_valid & ws_allowin) begin
         buf_vld   <= 1'b0;
         rdata_buf <= rdata_buf;
      end else if (data_ok_use & mem_wait & ~buf_vld & ~ws_allowin) begin
         buf_vld   <= 1'b1;
         rdata_buf <= data_sram_rdata;
      end else begin
         buf_vld   <= buf_vld;
         rdata_buf <= rdata_buf;
      end
   end

   // Orphaned requests: the waiting op being flushed, and an EXE request handed
   // over in the flush cycle that therefore never becomes valid in MEM.
   always_comb begin
      inc_wait = flush & mem_wait & ~buf_vld & ~data_ok_use;
      inc_hand = flush & es_to_ms_valid & ms_allowin & is_mem_op(bus_in) & ~bus_in.ex;
      dec_drop = data_sram_data_ok & (drop_cnt != 2'd0);
      drop_cnt_next = drop_cnt + {1'b0, inc_wait} + {1'b0, inc_hand} - {1'b0, dec_drop};
   end

   // Count of late responses still to be discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt <= 2'd0;
      end else begin
         drop_cnt <= drop_cnt_next;
      end
   end

   assign load_word = buf_vld ? rdata_buf : data_sram_rdata;

   mem_load_align u_align (
      .addr_lo (ms_bus.addr_lo),
      .ld      (ms_bus.ld),
      .word    (load_word),
      .result  (load_data)
   );

   // An ex'd load has no data; its result field carries the bad address.
   assign final_result = (ms_bus.res_from_mem & ~ms_bus.ex) ? load_data : ms_bus.result;

`ifdef MS_LOAD_FWD_EN
   assign data_vld   = ms_bus.res_from_mem ? ms_ready_go : 1'b1;
   assign fwd_result = final_result;
`else
   assign data_vld   = ~ms_bus.res_from_mem;
   assign fwd_result = ms_bus.result;
`endif

   assign ms_to_ws_bus = {ms_bus.rdcntid, ms_bus.ertn, ms_bus.esubcode, ms_bus.ecode,
                          ms_bus.ex, ms_bus.csr_re, ms_bus.csr_num, ms_bus.wvalue,
                          ms_bus.wmask, ms_bus.csr_we, ms_bus.gr_we, ms_bus.dest,
                          final_result, ms_bus.pc};

   assign ms_forward = {ms_bus.csr_re & ms_valid, ms_bus.csr_re, ms_bus.csr_num,
                        ms_bus.csr_we, ms_bus.ertn, ms_bus.ex, ms_bus.res_from_mem,
                        data_vld, fwd_result, ms_bus.dest, ms_bus.gr_we, ms_valid};

endmodule
